// File: rtl/calc_sequencer_if.sv
// Entry-decoder strobes in, display/status out for the three-number calculator sequencer.
interface calc_if;
  logic        clr;
  logic        num_valid;
  logic [9:0]  num_in;
  logic        op_valid;
  logic [1:0]  op_in;
  logic        eq_valid;
  logic [10:0] disp;
  logic        ovf;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output clr, num_valid, num_in, op_valid, op_in, eq_valid,
    input  disp, ovf, busy, done, err
  );

  modport slave (
    input  clr, num_valid, num_in, op_valid, op_in, eq_valid,
    output disp, ovf, busy, done, err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Left-to-right ((A op1 B) op2 C) calculator sequencer; each EXEC step takes one cycle.
// All outputs are registered; rejected strobes are dropped with a one-cycle err pulse.
module calc_sequencer (
  input  logic  clk,
  input  logic  rst,
  calc_if.slave io
);
  typedef enum logic [2:0] {
    WAIT_A, WAIT_OP1, WAIT_B, EXEC1, WAIT_OP2, WAIT_C, EXEC2, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] a_q, a_d, opnd_q, opnd_d, acc_q, acc_d, disp_q, disp_d;
  logic [1:0]  op1_q, op1_d, op2_q, op2_d;
  logic        ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic        multi, take_num, take_op, take_eq, any_strobe, in_exec;
  logic [10:0] num_sx, alu_x;
  logic [1:0]  alu_op;
  logic [11:0] alu_r;
  logic        alu_ovf;

  assign num_sx     = {io.num_in[9], io.num_in};
  assign multi      = (io.num_valid & io.op_valid) | (io.num_valid & io.eq_valid) |
                      (io.op_valid & io.eq_valid);
  assign take_num   = io.num_valid & ~multi;
  assign take_op    = io.op_valid & ~multi;
  assign take_eq    = io.eq_valid & ~multi;
  assign any_strobe = io.num_valid | io.op_valid | io.eq_valid;
  assign in_exec    = (state_q == EXEC1) || (state_q == EXEC2);

  // Exact 12-bit result; the 11-bit acc is its low bits, overflow is judged against 10-bit range.
  always_comb begin
    alu_x   = (state_q == EXEC2) ? acc_q : a_q;
    alu_op  = (state_q == EXEC2) ? op2_q : op1_q;
    alu_ovf = 1'b0;
    case (alu_op)
      2'b00:   alu_r = {alu_x[10], alu_x} + {opnd_q[10], opnd_q};
      2'b01:   alu_r = {alu_x[10], alu_x} - {opnd_q[10], opnd_q};
      2'b10:   alu_r = {1'b0, alu_x & opnd_q};
      default: alu_r = {1'b0, alu_x | opnd_q};
    endcase
    if (!alu_op[1])
      alu_ovf = ($signed(alu_r) < -12'sd512) || ($signed(alu_r) > 12'sd511);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      disp_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      disp_q  <= disp_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // EXEC states always advance; strobes arriving then are only flagged.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (io.clr) begin
      state_d = WAIT_A;
    end else if (in_exec) begin
      state_d = (state_q == EXEC1) ? WAIT_OP2 : DONE;
      err_d   = any_strobe;
    end else if (multi) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        WAIT_A:   begin if (take_num) state_d = WAIT_OP1; else err_d = any_strobe; end
        WAIT_OP1: begin if (take_op)  state_d = WAIT_B;   else err_d = any_strobe; end
        WAIT_B:   begin if (take_num) state_d = EXEC1;    else err_d = any_strobe; end
        WAIT_OP2: begin
          if (take_op)      state_d = WAIT_C;
          else if (take_eq) state_d = DONE;
          else              err_d   = any_strobe;
        end
        WAIT_C:   begin if (take_num) state_d = EXEC2;    else err_d = any_strobe; end
        DONE: begin
          if (take_num)     state_d = WAIT_OP1;
          else if (take_op) state_d = WAIT_B;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end

  always_comb begin
    a_d    = a_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    disp_d = disp_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    ovf_d  = ovf_q;
    busy_d = (state_d == EXEC1) || (state_d == EXEC2);
    done_d = (state_d == DONE);
    if (io.clr) begin
      a_d    = '0;
      opnd_d = '0;
      acc_d  = '0;
      disp_d = '0;
      op1_d  = '0;
      op2_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      case (state_q)
        WAIT_A:   if (take_num) begin a_d = num_sx; disp_d = num_sx; ovf_d = 1'b0; end
        WAIT_OP1: if (take_op) op1_d = io.op_in;
        WAIT_B:   if (take_num) begin opnd_d = num_sx; disp_d = num_sx; end
        WAIT_OP2: if (take_op) op2_d = io.op_in;
        WAIT_C:   if (take_num) begin opnd_d = num_sx; disp_d = num_sx; end
        EXEC1, EXEC2: begin
          acc_d  = alu_r[10:0];
          disp_d = alu_r[10:0];
          ovf_d  = ovf_q | alu_ovf;
        end
        DONE: begin
          // A chained operator reuses the result as A and keeps the overflow history.
          if (take_num) begin
            a_d    = num_sx;
            disp_d = num_sx;
            ovf_d  = 1'b0;
          end else if (take_op) begin
            a_d   = acc_q;
            op1_d = io.op_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.disp = disp_q;
  assign io.ovf  = ovf_q;
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.err  = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed and randomized bench for calc_sequencer against a token-counting calculator model.
module tb_calc_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_if cif ();
  calc_sequencer dut (.clk(clk), .rst(rst), .io(cif.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: how many operands/operators have been entered, pending evaluation, finished flag.
  int m_nums, m_ops, m_acc, m_opnd, m_disp;
  int m_opc [2];
  bit m_pend, m_fin, m_ovf, m_err;

  function automatic int wrap11(int r);
    return ((r + 1024) & 'h7FF) - 1024;
  endfunction

  function automatic void mreset();
    m_nums = 0; m_ops = 0; m_acc = 0; m_opnd = 0; m_disp = 0;
    m_opc[0] = 0; m_opc[1] = 0;
    m_pend = 0; m_fin = 0; m_ovf = 0; m_err = 0;
  endfunction

  function automatic void mstep(bit c, bit nv, int n, bit ov, int o, bit ev);
    int r;
    int op;
    m_err = 0;
    if (c) begin
      mreset();
    end else if (m_pend) begin
      op = m_opc[m_ops-1];
      case (op)
        0:       r = m_acc + m_opnd;
        1:       r = m_acc - m_opnd;
        2:       r = m_acc & m_opnd;
        default: r = m_acc | m_opnd;
      endcase
      if (op < 2 && (r < -512 || r > 511)) m_ovf = 1;
      m_acc  = wrap11(r);
      m_disp = m_acc;
      m_pend = 0;
      if (m_ops == 2) m_fin = 1;
      m_err = nv | ov | ev;
    end else if (int'(nv) + int'(ov) + int'(ev) > 1) begin
      m_err = 1;
    end else if (m_fin) begin
      if (nv) begin
        m_nums = 1; m_ops = 0; m_acc = n; m_disp = n; m_ovf = 0; m_fin = 0;
      end else if (ov) begin
        m_nums = 1; m_ops = 1; m_opc[0] = o; m_fin = 0;
      end
    end else if (nv) begin
      if (m_nums == m_ops) begin
        m_nums++;
        m_disp = n;
        if (m_nums == 1) m_acc = n;
        else begin m_opnd = n; m_pend = 1; end
      end else m_err = 1;
    end else if (ov) begin
      if (m_nums == m_ops + 1 && m_ops < 2) begin
        m_opc[m_ops] = o;
        m_ops++;
      end else m_err = 1;
    end else if (ev) begin
      if (m_nums == 2 && m_ops == 1) m_fin = 1;
      else m_err = 1;
    end
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("disp", int'(cif.disp), m_disp & 'h7FF);
    chk("ovf",  int'(cif.ovf),  int'(m_ovf));
    chk("busy", int'(cif.busy), int'(m_pend));
    chk("done", int'(cif.done), int'(m_fin));
    chk("err",  int'(cif.err),  int'(m_err));
  endtask

  task automatic drive(bit c, bit nv, int n, bit ov, int o, bit ev);
    cif.clr = c; cif.num_valid = nv; cif.num_in = 10'(n);
    cif.op_valid = ov; cif.op_in = 2'(o); cif.eq_valid = ev;
  endtask

  task automatic cyc(bit c, bit nv, int n, bit ov, int o, bit ev);
    @(negedge clk);
    drive(c, nv, n, ov, o, ev);
    @(posedge clk);
    mstep(c, nv, n, ov, o, ev);
    #1 compare();
  endtask

  task automatic num(int v);  cyc(0, 1, v, 0, 0, 0); endtask
  task automatic op(int o);   cyc(0, 0, 0, 1, o, 0); endtask
  task automatic eq();        cyc(0, 0, 0, 0, 0, 1); endtask
  task automatic idle();      cyc(0, 0, 0, 0, 0, 0); endtask
  task automatic clr();       cyc(1, 0, 0, 0, 0, 0); endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp", int'(cif.disp), 0);
    chk("rst_done", int'(cif.done), 0);
    chk("rst_busy", int'(cif.busy), 0);
    @(negedge clk) rst = 1'b0;

    // 5 + 7 - 3
    num(5); op(0); num(7);
    chk("add_busy", int'(cif.busy), 1);
    idle();
    chk("add_exec1", int'(cif.disp), 12);
    op(0); num(-3); idle();
    chk("add_done", int'(cif.done), 1);
    chk("add_res", int'(cif.disp), 9);

    // overflow 511 + 1 + 0
    num(511); op(0); num(1); idle();
    chk("ovf_exec1", int'(cif.disp), 'h200);
    chk("ovf_flag", int'(cif.ovf), 1);
    op(0); num(0); idle();
    chk("ovf_res", int'(cif.disp), 'h200);
    chk("ovf_sticky", int'(cif.ovf), 1);

    // logic ops
    num('h0F0); op(2); num('h03C); idle(); eq();
    chk("and_res", int'(cif.disp), 'h030);
    chk("and_ovf", int'(cif.ovf), 0);
    num(-1); op(3); num(0); idle();
    chk("or_res", int'(cif.disp), 'h7FF);
    eq();

    // chaining below -512
    num(-512); op(1); num(1); idle(); eq();
    chk("chain1", int'(cif.disp), 'h5FF);
    chk("chain1_ovf", int'(cif.ovf), 1);
    op(1); num(1); idle(); eq();
    chk("chain2", int'(cif.disp), 'h5FE);
    chk("chain2_ovf", int'(cif.ovf), 1);

    // protocol errors
    clr(); op(0);
    chk("err_op_wait_a", int'(cif.err), 1);
    num(5); cyc(0, 1, 9, 1, 1, 0);
    chk("err_multi", int'(cif.err), 1);
    op(0); num(3); num(9);
    chk("err_exec1", int'(cif.err), 1);
    chk("exec1_res", int'(cif.disp), 8);

    // clear in WAIT_C
    op(0); clr();
    chk("clr_disp", int'(cif.disp), 0);

    // async reset during EXEC2
    num(1); op(0); num(2); idle(); op(0); num(3);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("arst_disp", int'(cif.disp), 0);
    chk("arst_busy", int'(cif.busy), 0);
    mreset();
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    idle();
    chk("arst_no_done", int'(cif.done), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int pick, v, o;
      pick = int'($urandom_range(0, 15));
      v    = int'($urandom_range(0, 1023)) - 512;
      o    = int'($urandom_range(0, 3));
      if (pick <= 4)       num(v);
      else if (pick <= 8)  op(o);
      else if (pick <= 10) eq();
      else if (pick == 11) cyc(0, 1'($urandom), v, 1'($urandom), o, 1'($urandom));
      else if (pick == 12 && $urandom_range(0, 3) == 0) clr();
      else                 idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Sequencing controller for the three-number calculator. Accepts up to three 10-bit two's-complement operands and two operators as single-cycle strobes, evaluates strictly left to right, ((A op1 B) op2 C), on an internal 11-bit datapath, and presents an 11-bit result with a sticky overflow flag. It sits between the keypad/entry decoder and the display driver and owns every ALU step.

## Interface
- No parameters; all buses are fixed at the library standard of 11 bits, with bit 10 reserved for overflow/sign extension.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear strobe; returns to WAIT_A
- num_valid  in  1  operand strobe; num_in is sampled this cycle
- num_in  in  10  operand, two's complement, range -512..511
- op_valid  in  1  operator strobe; op_in is sampled this cycle
- op_in  in  2  operator: 00 ADD, 01 SUB (acc - operand), 10 AND, 11 OR
- eq_valid  in  1  equals strobe
- disp  out  11  display value: last accepted operand (sign-extended) or result
- ovf  out  1  sticky overflow for the current calculation
- busy  out  1  high in the EXEC1 and EXEC2 states
- done  out  1  high in the DONE state; disp holds the final result
- err  out  1  one-cycle pulse when an input is rejected

## Operation
- States: WAIT_A, WAIT_OP1, WAIT_B, EXEC1, WAIT_OP2, WAIT_C, EXEC2, DONE.
- WAIT_A + num → WAIT_OP1. Latch A, and set disp = sext(A).
- WAIT_OP1 + op → WAIT_B. Latch op1.
- WAIT_B + num → EXEC1. Latch B, and set disp = sext(B).
- EXEC1, with no input needed: acc = A op1 B, disp = acc → WAIT_OP2.
- WAIT_OP2 + op → WAIT_C. Latch op2.
- WAIT_OP2 + eq → DONE. This is the two-operand result.
- WAIT_C + num → EXEC2. Latch C, and set disp = sext(C).
- EXEC2: acc = acc op2 C, disp = acc → DONE.
- DONE + num → WAIT_OP1. This starts a new calculation with the strobe as A, and clears ovf.
- DONE + op → WAIT_B. This chains: A = current acc, op1 = op_in, and ovf is retained.
- DONE + eq: ignored, with no err.
- Arithmetic rules:
  - Operands are sign-extended to 11 bits.
  - Each step computes the exact 12-bit result r.
  - acc takes r[10:0].
  - ovf is set if r < -512 or r > 511, and stays set until clr, rst, or a new A from DONE/WAIT_A.
  - AND and OR operate bitwise on the 11-bit values and never set ovf.
  - A chained acc outside the 10-bit range is a legal 11-bit input.
- Input priority:
  - clr overrides everything.
  - Two or more of num/op/eq high in the same cycle: all are ignored, err pulses, and state is unchanged.
- A strobe that is not legal in the current state is ignored and pulses err. Examples: op in WAIT_A, eq in WAIT_B, num in WAIT_OP1.
- Any strobe during EXEC1 or EXEC2 is ignored and pulses err.

## Timing
- Reset values: state = WAIT_A, disp = 0, ovf = 0, busy = 0, done = 0, err = 0, and all latches = 0.
- rst is asynchronous on assertion. Release is synchronous to clk, and the first strobe is accepted on the first rising edge after deassertion.
- All outputs are registered, with no combinational path from inputs to outputs.
- Strobes are sampled on a rising edge. disp updates on that same edge for operand capture.
- EXEC states last exactly one cycle.
- Latency from the C strobe edge to done = 1: 2 cycles (C captured, then EXEC2).
- Latency from eq in WAIT_OP2 to done: 1 cycle.
- err is high for exactly the cycle after the offending edge.
- clr: next edge → WAIT_A, disp = 0, ovf = 0, done = 0.
- rst mid-EXEC: the partial result is discarded and all outputs return to reset values.

## Test plan
- Three-number add: 5, ADD, 7, ADD, -3 → after EXEC1 disp = 12; done = 1 with disp = 9 and ovf = 0; busy high for exactly 1 cycle each time.
- Overflow: 511, ADD, 1, ADD, 0 → disp = 512 (0x200), ovf = 1; done with disp = 512 and ovf still 1.
- Two-operand equals and logic: 0x0F0, AND, 0x03C, eq → disp = 0x030, done = 1, ovf = 0. Then -1, OR, 0 → disp = 0x7FF.
- Chaining: -512, SUB, 1, eq → disp = -513 (0x5FF), ovf = 1. Then op SUB, num 1, eq → disp = -514 (0x5FE), ovf = 1.
- Protocol errors:
  - op in WAIT_A → err pulse, state stays WAIT_A.
  - num and op together in WAIT_OP1 → err pulse, nothing latched.
  - num during EXEC1 → err pulse, result unaffected.
- Clear and reset: clr in WAIT_C → WAIT_A, disp = 0. rst asserted asynchronously during EXEC2 → all outputs 0 immediately, done never asserts.
